// File: rtl/or3_rr_arbiter.sv
// Three-lane round-robin arbiter with a bounded hold time per owner.
// any_req is the combinational OR of the requests; grant and its companions are registered.
module or3_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic       any_req,
  output logic [2:0] grant,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] HoldLim = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       grant_q, grant_d;
  logic             grant_valid_q, grant_valid_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic             timeout_q, timeout_d;

  function automatic logic [1:0] next3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // First asserted candidate in the order start, start+1, start+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] cand, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    logic [1:0] win;
    idx   = start;
    found = 1'b0;
    win   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = next3(idx);
    end
    return win;
  endfunction

  logic       owner_req;
  logic [2:0] others;
  logic [1:0] winner;
  logic       do_grant;

  assign any_req   = req[0] | req[1] | req[2];
  assign owner_req = req[grant_id_q];
  assign others    = req & ~(3'b001 << grant_id_q);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    timeout_d     = 1'b0;
    do_grant      = 1'b0;
    winner        = rr_pick(req, ptr_q);

    unique case (state_q)
      StIdle: begin
        if (any_req) do_grant = 1'b1;
      end
      StBusy: begin
        if (!owner_req) begin
          if (|others) begin
            do_grant = 1'b1;
          end else begin
            state_d       = StIdle;
            grant_d       = 3'b000;
            grant_valid_d = 1'b0;
          end
        end else if (hold_cnt_q < HoldLim) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (|others) begin
          // Owner excluded from the search so the forced rotation always moves on.
          winner    = rr_pick(others, ptr_q);
          do_grant  = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (do_grant) begin
      state_d       = StBusy;
      grant_d       = 3'b001 << winner;
      grant_valid_d = 1'b1;
      grant_id_d    = winner;
      ptr_d         = next3(winner);
      hold_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= 2'd0;
      hold_cnt_q    <= '0;
      grant_q       <= 3'b000;
      grant_valid_q <= 1'b0;
      grant_id_q    <= 2'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/or3_rr_arbiter.md
Name: or3_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among three requesters (a, b, c lanes).
- A combinational three-input OR of the requests gives the "any request pending" indication; registered state decides which requester owns the resource.
- The controller sits between the request sources and the shared datapath. It issues a one-hot grant with a bounded hold time, so no requester can starve the others.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant while another requester waits; legal range 2..15.
- CNT_W, 4: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  3  request vector; bit0=a, bit1=b, bit2=c; level-sensitive, held high while the requester wants the resource.
- any_req  output  1  combinational OR of req[0], req[1] and req[2].
- grant  output  3  registered one-hot grant; all zero when idle.
- grant_valid  output  1  registered; high when grant is nonzero.
- grant_id  output  2  registered encoded owner, 0..2; holds the last owner when idle.
- timeout  output  1  registered one-cycle pulse on forced rotation.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - grant=000, grant_valid=0, grant_id=0, timeout=0.
  - Priority pointer ptr=0, so requester a has first priority.
  - hold_cnt=0, state=IDLE.
- Reset mid-operation: rst wins over every other event. Grant drops at the same edge that samples rst=1, with no timeout pulse.
- Output timing:
  - any_req has zero latency and is purely combinational.
  - All other outputs are registered.
- Round-robin selection: search order starts at ptr and proceeds ptr, ptr+1, ptr+2, all mod 3. The first asserted candidate wins.
- On every new grant to requester i:
  - ptr becomes (i+1) mod 3.
  - hold_cnt becomes 0.
- IDLE state:
  - If any_req=1 at edge N, grant the RR winner; the grant is visible after edge N, so latency is 1 cycle. Go to BUSY.
  - Otherwise stay in IDLE with all outputs at their idle values.
- BUSY state, owner o:
  - Release: req[o]=0 at an edge.
    - If another req is asserted, grant moves directly to the RR winner at that edge, with no bubble cycle.
    - If no other req is asserted, grant=000 and the state returns to IDLE.
  - Hold: req[o]=1 and hold_cnt < MAX_HOLD-1.
    - Keep the grant and increment hold_cnt.
  - Limit: req[o]=1 and hold_cnt = MAX_HOLD-1.
    - If another req is asserted, force rotation to the RR winner among the others (o excluded) and pulse timeout=1 for one cycle.
    - If no other req is asserted, o keeps the grant and hold_cnt saturates at MAX_HOLD-1; no timeout.
- Simultaneous events:
  - Owner release and other requests at the same edge: normal release handling; timeout stays 0 even if the limit was reached.
  - Multiple new requests in IDLE: pure ptr order.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid equals the OR of the grant bits.
  - grant_id matches the grant bit whenever grant_valid=1.
  - The owner is never switched unless it released or hit the limit.
- Requests dropping while not granted are ignored, with no latching. The arbiter keeps no request memory beyond ptr.

Test Plan:
- Reset then single request: rst for 2 cycles, then req=001 at edge 3 -> after edge 3 grant=001, grant_id=0, grant_valid=1. Drop req at edge 6 -> grant=000 after edge 6. any_req follows req with no delay.
- Round-robin fairness: req=111 held, each owner drops its bit for 1 cycle after 2 cycles of ownership, then reasserts it -> grant order a, b, c, a, with no idle cycle between owners.
- Forced rotation (MAX_HOLD=8): req=011 held constant from reset -> a owns for exactly 8 cycles, then grant=010 with timeout=1 for one cycle. After b's 8 cycles, grant returns to a.
- Saturation, no starvation risk: req=100 only, held 20 cycles -> grant=100 throughout, timeout never asserts. Add req bit0 at cycle 20 -> rotation to a on the next edge with a timeout pulse.
- Simultaneous release and limit: owner a drops req at the same edge hold_cnt reaches 7 while b requests -> grant=010, timeout=0.
- Reset mid-grant: grant=010 active, rst=1 for one edge -> grant=000, grant_id=0, ptr=0. With req=111 after rst falls, a is granted first.
